// File: rtl/uart_rx.sv
// 8N1 UART receiver with a fixed D clocks per bit, mid-bit sampling and a
// BREAK state that absorbs a held-low line after a framing error.
module uart_rx #(
   parameter int D = 5
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rxd,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_ferr,
   output logic       o_busy
);

   localparam int CW = (D > 1) ? $clog2(D) : 1;
   localparam logic [CW-1:0] H_C    = CW'((D - 1) / 2);
   localparam logic [CW-1:0] LAST_C = CW'(D - 1);
   localparam logic [CW-1:0] ONE_C  = CW'(1);
   localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   logic [1:0]    sync_q;
   logic          rxd_s;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    sh_q, sh_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          busy_q, busy_d;

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], i_rxd};
      end
   end

   assign rxd_s = sync_q[1];

   // Frame FSM and datapath registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= ZERO_C;
         idx_q   <= 3'd0;
         sh_q    <= 8'h00;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state logic; strobes default low so each lasts exactly one cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      sh_d    = sh_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rxd_s) begin
               cnt_d   = ZERO_C;
               state_d = S_START;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (cnt_q != H_C) begin
               cnt_d = cnt_q + ONE_C;
            end else if (!rxd_s) begin
               cnt_d   = ZERO_C;
               idx_d   = 3'd0;
               state_d = S_DATA;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_DATA: begin
            if (cnt_q != LAST_C) begin
               cnt_d = cnt_q + ONE_C;
            end else begin
               sh_d  = {rxd_s, sh_q[7:1]};
               cnt_d = ZERO_C;
               idx_d = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_STOP: begin
            if (cnt_q != LAST_C) begin
               cnt_d = cnt_q + ONE_C;
            end else if (rxd_s) begin
               data_d  = sh_q;
               valid_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               ferr_d  = 1'b1;
               state_d = S_BREAK;
            end
         end
         // Hold here until the line recovers so a stuck-low line yields one error.
         S_BREAK: begin
            if (rxd_s) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_BREAK;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   assign o_data  = data_q;
   assign o_valid = valid_q;
   assign o_ferr  = ferr_q;
   assign o_busy  = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial stimulus, expected bytes queued at send
// time and popped by a monitor on every o_valid strobe.
module tb_uart_rx;

   localparam int D = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       line = 1'b1;
   logic       use_tx = 1'b0;
   logic       tx_txd;
   logic       rxd;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_ferr;
   logic       o_busy;

   int checks = 0;
   int errors = 0;
   int valid_cnt = 0;
   int ferr_cnt = 0;
   int cyc = 0;
   int t_prev = 0;
   int t_last = 0;
   logic [7:0] exp_q[$];

   // bench-side character transmitter used for loopback
   logic [9:0] tx_sh = 10'h3FF;
   int         tx_bits = 0;
   int         tx_cnt = 0;
   logic [3:0] tx_load = 4'd0;
   logic       tx_send = 1'b0;
   logic [7:0] tx_chars [16];

   assign rxd = use_tx ? tx_txd : line;
   assign tx_txd = (tx_bits > 0) ? tx_sh[0] : 1'b1;

   uart_rx #(.D(D)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_rxd  (rxd),
      .o_data (o_data),
      .o_valid(o_valid),
      .o_ferr (o_ferr),
      .o_busy (o_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (tx_send) begin
         tx_sh   <= {1'b1, tx_chars[tx_load], 1'b0};
         tx_bits <= 10;
         tx_cnt  <= 0;
      end else if (tx_bits > 0) begin
         if (tx_cnt == D - 1) begin
            tx_cnt  <= 0;
            tx_sh   <= {1'b1, tx_sh[9:1]};
            tx_bits <= tx_bits - 1;
         end else begin
            tx_cnt <= tx_cnt + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      chk("valid_ferr_exclusive", {31'd0, o_valid & o_ferr}, 32'd0);
      if (o_valid) begin
         valid_cnt++;
         t_prev = t_last;
         t_last = cyc;
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", exp_q.size(), 32'd1);
         end else begin
            chk("rx_data", {24'd0, o_data}, {24'd0, exp_q.pop_front()});
         end
      end
      if (o_ferr) ferr_cnt++;
   end

   task automatic drive_bit(input logic v);
      line = v;
      repeat (D) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop);
   endtask

   task automatic wait_valid(input int n, input string tag);
      for (int i = 0; i < 300 && valid_cnt < n; i++) @(negedge clk);
      chk(tag, valid_cnt, n);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int v0;
      int f0;
      logic seen_busy;
      for (int i = 0; i < 16; i++) tx_chars[i] = (i < 10) ? 8'(8'h30 + i) : 8'(8'h41 + i - 10);

      // reset
      #1 rst = 1'b1;
      #1;
      chk("reset_data", {24'd0, o_data}, 32'h00);
      chk("reset_valid", {31'd0, o_valid}, 32'd0);
      chk("reset_ferr", {31'd0, o_ferr}, 32'd0);
      chk("reset_busy", {31'd0, o_busy}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // nominal byte
      exp_q.push_back(8'h41);
      send_frame(8'h41, 1'b1);
      wait_valid(1, "nominal_valid");
      chk("nominal_ferr", ferr_cnt, 0);
      chk("nominal_busy", {31'd0, o_busy}, 32'd0);

      // glitch rejection
      seen_busy = 1'b0;
      line = 1'b0;
      repeat (2) @(posedge clk);
      #1 line = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (o_busy) seen_busy = 1'b1;
      end
      chk("glitch_busy_pulse", {31'd0, seen_busy}, 32'd1);
      chk("glitch_no_valid", valid_cnt, 1);
      chk("glitch_no_ferr", ferr_cnt, 0);
      chk("glitch_idle", {31'd0, o_busy}, 32'd0);
      @(posedge clk);
      #1;
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1);
      wait_valid(2, "after_glitch_valid");

      // framing error
      exp_q.push_back(8'h41);
      send_frame(8'h41, 1'b1);
      wait_valid(3, "pre_ferr_valid");
      v0 = valid_cnt;
      send_frame(8'hC3, 1'b0);
      line = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("ferr_pulse", ferr_cnt, 1);
      chk("ferr_busy_held", {31'd0, o_busy}, 32'd1);
      chk("ferr_data_kept", {24'd0, o_data}, 32'h41);
      #1 line = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("ferr_busy_released", {31'd0, o_busy}, 32'd0);
      chk("ferr_no_valid", valid_cnt, v0);
      @(posedge clk);
      #1;

      // back-to-back
      exp_q.push_back(8'h55);
      exp_q.push_back(8'hAA);
      send_frame(8'h55, 1'b1);
      send_frame(8'hAA, 1'b1);
      wait_valid(v0 + 2, "b2b_valid");
      chk("b2b_spacing", t_last - t_prev, 50);

      // reset mid-frame during data bit 3 of 0xFF
      v0 = valid_cnt;
      f0 = ferr_cnt;
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      drive_bit(1'b1);
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("midrst_data", {24'd0, o_data}, 32'h00);
      chk("midrst_busy", {31'd0, o_busy}, 32'd0);
      chk("midrst_valid", {31'd0, o_valid}, 32'd0);
      chk("midrst_ferr", {31'd0, o_ferr}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      line = 1'b1;
      rst = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      chk("midrst_no_valid", valid_cnt, v0);
      chk("midrst_no_ferr", ferr_cnt, f0);
      exp_q.push_back(8'h7E);
      send_frame(8'h7E, 1'b1);
      wait_valid(v0 + 1, "post_reset_valid");
      chk("post_reset_data", {24'd0, o_data}, 32'h7E);

      // loopback from the bench transmitter, count 10 selects 'A'
      v0 = valid_cnt;
      use_tx = 1'b1;
      tx_load = 4'd10;
      exp_q.push_back(8'h41);
      tx_send = 1'b1;
      @(posedge clk);
      #1 tx_send = 1'b0;
      wait_valid(v0 + 1, "loopback_valid");
      chk("loopback_data", {24'd0, o_data}, 32'h41);

      chk("queue_drained", exp_q.size(), 32'd0);
      chk("total_ferr", ferr_cnt, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
